// File: rtl/popcount_accum_pipe_if.sv
// popcount_accum_pipe_if
//   Beat input stream and frame-result output stream of popcount_accum_pipe.
//   IN_W and ACC_W must match the parameters of the attached block.
//   master : producer of beats / consumer of results (drives in_*, out_ready)
//   slave  : the popcount block (drives in_ready, out_*)
//   Signals:
//     in_valid/in_ready  beat handshake
//     in_data, in_mask   bit vector and per-bit enable
//     in_last            final beat of a frame
//     mode_zero          0 counts ones, 1 counts zeros (per beat)
//     out_valid/out_ready result handshake
//     out_sum, out_beats frame total and beat count
//     out_ovf            an accumulator overflowed during the frame
interface popcount_accum_pipe_if #(
  parameter int IN_W  = 15,
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [IN_W-1:0]  in_mask;
  logic             in_last;
  logic             mode_zero;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [ACC_W-1:0] out_beats;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_mask, in_last, mode_zero, out_ready,
    input  in_ready, out_valid, out_sum, out_beats, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_mask, in_last, mode_zero, out_ready,
    output in_ready, out_valid, out_sum, out_beats, out_ovf
  );
endinterface

// File: rtl/popcount_accum_pipe.sv
// popcount_accum_pipe
//   Pipelined masked popcount with per-frame accumulation.
//   Each accepted beat contributes popcount((mode_zero ? ~data : data) & mask)
//   to a frame total; the frame closes on in_last and its total, beat count
//   and overflow flag are presented on a valid/ready result register.
//
//   Parameters:
//     IN_W     input vector width (2..64)
//     ACC_W    sum / beat accumulator width (>= clog2(IN_W+1))
//     PIPE_STG register stages inside the compressor tree (0..3)
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset
//     clr    synchronous flush of frame state, pipeline and result valid
//     bus    popcount_accum_pipe_if.slave (beat input, result output)
//
//   Build option:
//     POPCNT_SAT_EN  defined   -> accumulators saturate at 2^ACC_W-1
//                    undefined -> accumulators wrap modulo 2^ACC_W
//     out_ovf flags saturation/wrap in both builds.

// Per-group bit counter: one leaf of the compressor tree.
module popcount_accum_pipe_grp #(
  parameter int GW = 8,
  parameter int CW = 4
) (
  input  logic [GW-1:0] bits,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < GW; i++) cnt = cnt + CW'(bits[i]);
  end
endmodule

module popcount_accum_pipe #(
  parameter int IN_W     = 15,
  parameter int ACC_W    = 16,
  parameter int PIPE_STG = 1
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  clr,
  popcount_accum_pipe_if.slave bus
);
  localparam int CW    = $clog2(IN_W + 1);
  // Tree shape: 2^PIPE_STG leaf groups reduced by a binary adder tree whose
  // every node output is registered, so each tree level is one pipe stage.
  localparam int G     = 1 << PIPE_STG;
  localparam int GW    = (IN_W + G - 1) / G;
  localparam int PAD_W = G * GW;
  localparam int NN    = 2 * G - 1;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] beats;
    logic             ovf;
  } res_t;

  // ---------------------------------------------------------------------------
  // Handshake / stall
  // ---------------------------------------------------------------------------
  logic en, take, out_vld;
  res_t res_q;

  // Everything freezes while a result is held and not being taken.
  assign en           = !(out_vld && !bus.out_ready);
  assign bus.in_ready = en && !clr;
  assign take         = bus.in_valid && en && !clr;

  // ---------------------------------------------------------------------------
  // Stage 0: select ones/zeros, apply mask, count per group
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0]          bits;
  logic [PAD_W-1:0]         bits_pad;
  // Heap-ordered tree: node 0 is the root, children of n are 2n+1 and 2n+2,
  // leaves occupy G-1..NN-1.
  logic [NN-1:0][CW-1:0]    node;
  logic [PIPE_STG:0]        vld_pipe, last_pipe;

  assign bits     = (bus.mode_zero ? ~bus.in_data : bus.in_data) & bus.in_mask;
  // Padding bits are zero and never count.
  assign bits_pad = PAD_W'(bits);

  for (genvar g = 0; g < G; g++) begin : g_grp
    popcount_accum_pipe_grp #(.GW(GW), .CW(CW)) u_grp (
      .bits (bits_pad[g*GW +: GW]),
      .cnt  (node[G-1+g])
    );
  end

  // ---------------------------------------------------------------------------
  // Registered reduction tree
  // ---------------------------------------------------------------------------
  if (PIPE_STG > 0) begin : g_tree
    logic [NN-1:1][CW-1:0] nq;
    logic [PIPE_STG-1:0]   vq, lq;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        nq <= '0;
        vq <= '0;
        lq <= '0;
      end else if (clr) begin
        vq <= '0;
      end else if (en) begin
        nq <= node[NN-1:1];
        vq <= vld_pipe[PIPE_STG-1:0];
        lq <= last_pipe[PIPE_STG-1:0];
      end
    end

    for (genvar n = 0; n < G - 1; n++) begin : g_add
      assign node[n] = nq[2*n+1] + nq[2*n+2];
    end

    assign vld_pipe  = {vq, take};
    assign last_pipe = {lq, bus.in_last};
  end else begin : g_flat
    assign vld_pipe  = take;
    assign last_pipe = bus.in_last;
  end

  // ---------------------------------------------------------------------------
  // Accumulate at tree exit
  // ---------------------------------------------------------------------------
  logic             ex_vld, ex_last, ovf_add;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] sum_acc, beat_acc, sum_nxt, beat_nxt;
  logic             ovf_acc;
  logic [ACC_W:0]   sum_add, beat_add;

  assign ex_vld   = vld_pipe[PIPE_STG];
  assign ex_last  = last_pipe[PIPE_STG];
  assign cnt      = node[0];

  assign sum_add  = {1'b0, sum_acc}  + (ACC_W+1)'(cnt);
  assign beat_add = {1'b0, beat_acc} + (ACC_W+1)'(1);
  assign ovf_add  = sum_add[ACC_W] | beat_add[ACC_W];

`ifdef POPCNT_SAT_EN
  // A carry out means the true value passed the max; pin to all-ones. Once
  // pinned, any further non-zero add carries again and stays pinned.
  assign sum_nxt  = sum_add[ACC_W]  ? '1 : sum_add[ACC_W-1:0];
  assign beat_nxt = beat_add[ACC_W] ? '1 : beat_add[ACC_W-1:0];
`else
  assign sum_nxt  = sum_add[ACC_W-1:0];
  assign beat_nxt = beat_add[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_acc  <= '0;
      beat_acc <= '0;
      ovf_acc  <= 1'b0;
      out_vld  <= 1'b0;
      res_q    <= '0;
    end else if (clr) begin
      // Result payload is kept; only its valid is dropped.
      sum_acc  <= '0;
      beat_acc <= '0;
      ovf_acc  <= 1'b0;
      out_vld  <= 1'b0;
    end else if (en) begin
      if (ex_vld && ex_last) begin
        // Close the frame: publish the total including this beat and restart
        // the accumulators in the same edge so the next beat is not lost.
        res_q    <= '{sum: sum_nxt, beats: beat_nxt, ovf: ovf_acc | ovf_add};
        out_vld  <= 1'b1;
        sum_acc  <= '0;
        beat_acc <= '0;
        ovf_acc  <= 1'b0;
      end else begin
        // en with out_vld set implies out_ready: the held result is consumed.
        out_vld <= 1'b0;
        if (ex_vld) begin
          sum_acc  <= sum_nxt;
          beat_acc <= beat_nxt;
          ovf_acc  <= ovf_acc | ovf_add;
        end
      end
    end
  end

  assign bus.out_valid = out_vld;
  assign bus.out_sum   = res_q.sum;
  assign bus.out_beats = res_q.beats;
  assign bus.out_ovf   = res_q.ovf;
endmodule

// File: tb/tb_popcount_accum_pipe.sv
// Bench for popcount_accum_pipe: main instance IN_W=15/ACC_W=16/PIPE_STG=1
// driven with directed and random beats against a frame-level model, plus a
// small ACC_W=5/PIPE_STG=0 instance for overflow and zero-latency behaviour.
module tb_popcount_accum_pipe;
  localparam int OVF_SUM =
`ifdef POPCNT_SAT_EN
    31;
`else
    13;
`endif

  logic clk = 1'b0;
  logic reset, clr, clr_s;
  logic rand_rdy = 1'b0;
  always #5 clk = ~clk;

  popcount_accum_pipe_if #(.IN_W(15), .ACC_W(16)) bus_m ();
  popcount_accum_pipe_if #(.IN_W(15), .ACC_W(5))  bus_s ();

  popcount_accum_pipe #(.IN_W(15), .ACC_W(16), .PIPE_STG(1)) u_dut (
    .clk(clk), .reset(reset), .clr(clr), .bus(bus_m));
  popcount_accum_pipe #(.IN_W(15), .ACC_W(5), .PIPE_STG(0)) u_dut_s (
    .clk(clk), .reset(reset), .clr(clr_s), .bus(bus_s));

  int checks = 0;
  int errors = 0;

  typedef struct { int sum; int beats; bit ovf; } res_t;
  res_t exp_q[$];
  res_t got[$];
  int   msum, mbeats;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame-level model: true integer totals, then wrap or saturate.
  function automatic res_t close_frame(input int s, input int b, input int acc_w);
    res_t r;
    int   mx = (1 << acc_w) - 1;
    r.ovf = (s > mx) || (b > mx);
`ifdef POPCNT_SAT_EN
    r.sum   = (s > mx) ? mx : s;
    r.beats = (b > mx) ? mx : b;
`else
    r.sum   = s % (mx + 1);
    r.beats = b % (mx + 1);
`endif
    return r;
  endfunction

  // Monitor / scoreboard for the main instance, sampled mid-cycle.
  logic stall_prev = 1'b0;
  res_t held;
  always @(negedge clk) begin
    int   c;
    res_t e;
    if (!reset) begin
      msum = 0; mbeats = 0; exp_q.delete(); stall_prev = 1'b0;
    end else begin
      chk("in_ready", 32'(bus_m.in_ready),
          32'(!(bus_m.out_valid && !bus_m.out_ready) && !clr));
      if (stall_prev) begin
        chk("stall_valid", 32'(bus_m.out_valid), 32'(1));
        chk("stall_sum",   32'(bus_m.out_sum),   32'(held.sum));
        chk("stall_beats", 32'(bus_m.out_beats), 32'(held.beats));
        chk("stall_ovf",   32'(bus_m.out_ovf),   32'(held.ovf));
      end
      if (clr) begin
        msum = 0; mbeats = 0; exp_q.delete(); stall_prev = 1'b0;
      end else begin
        if (bus_m.in_valid && bus_m.in_ready) begin
          c = 0;
          for (int i = 0; i < 15; i++)
            if (bus_m.in_mask[i] && (bus_m.in_data[i] != bus_m.mode_zero)) c++;
          msum += c;
          mbeats++;
          if (bus_m.in_last) begin
            exp_q.push_back(close_frame(msum, mbeats, 16));
            msum = 0; mbeats = 0;
          end
        end
        if (bus_m.out_valid && bus_m.out_ready) begin
          got.push_back('{sum: int'(bus_m.out_sum), beats: int'(bus_m.out_beats),
                          ovf: bus_m.out_ovf});
          checks++;
          assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL extra_result observed=%0d expected=none", bus_m.out_sum);
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("res_sum",   32'(bus_m.out_sum),   32'(e.sum));
            chk("res_beats", 32'(bus_m.out_beats), 32'(e.beats));
            chk("res_ovf",   32'(bus_m.out_ovf),   32'(e.ovf));
          end
        end
        stall_prev = bus_m.out_valid && !bus_m.out_ready;
        held = '{sum: int'(bus_m.out_sum), beats: int'(bus_m.out_beats), ovf: bus_m.out_ovf};
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 bus_m.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat on the main bus and hold it until accepted (bounded).
  task automatic send(input logic [14:0] d, input logic [14:0] m,
                      input logic mz, input logic lst);
    bit ok = 1'b0;
    bus_m.in_data = d; bus_m.in_mask = m; bus_m.mode_zero = mz;
    bus_m.in_last = lst; bus_m.in_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = bus_m.in_ready;
      @(posedge clk);
      #1;
    end
    bus_m.in_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'(1));
  endtask

  task automatic send_s(input logic [14:0] d, input logic lst);
    bus_s.in_data = d; bus_s.in_mask = 15'h7FFF; bus_s.mode_zero = 1'b0;
    bus_s.in_last = lst; bus_s.in_valid = 1'b1;
    @(negedge clk);
    chk("s_in_ready", 32'(bus_s.in_ready), 32'(1));
    @(posedge clk);
    #1;
    bus_s.in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; clr_s = 1'b0;
    bus_m.in_valid = 1'b0; bus_m.in_data = '0; bus_m.in_mask = '0;
    bus_m.in_last = 1'b0; bus_m.mode_zero = 1'b0; bus_m.out_ready = 1'b1;
    bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.in_mask = '0;
    bus_s.in_last = 1'b0; bus_s.mode_zero = 1'b0; bus_s.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_valid", 32'(bus_m.out_valid), 32'(0));
    chk("rst_sum",   32'(bus_m.out_sum),   32'(0));
    chk("rst_beats", 32'(bus_m.out_beats), 32'(0));
    chk("rst_ovf",   32'(bus_m.out_ovf),   32'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    cycles(1);
    chk("rel_in_ready", 32'(bus_m.in_ready), 32'(1));

    // Latency of one stage, 7FFF -> 15
    send(15'h7FFF, 15'h7FFF, 1'b0, 1'b1);
    chk("lat_e0_valid", 32'(bus_m.out_valid), 32'(0));
    cycles(1);
    chk("lat_e1_valid", 32'(bus_m.out_valid), 32'(1));
    chk("lat_sum",      32'(bus_m.out_sum),   32'(15));
    chk("lat_beats",    32'(bus_m.out_beats), 32'(1));

    send(15'h5555, 15'h7FFF, 1'b0, 1'b1);
    cycles(1);
    chk("p5555_sum", 32'(bus_m.out_sum), 32'(8));

    // 4-beat frame then back-to-back 2-beat frame
    cycles(2);
    got.delete();
    send(15'h7FFF, 15'h7FFF, 1'b0, 1'b0);
    send(15'h0001, 15'h7FFF, 1'b0, 1'b0);
    send(15'h0000, 15'h7FFF, 1'b0, 1'b0);
    send(15'h00FF, 15'h7FFF, 1'b0, 1'b1);
    send(15'h0003, 15'h7FFF, 1'b0, 1'b0);
    send(15'h0F00, 15'h7FFF, 1'b0, 1'b1);
    cycles(3);
    chk("f4_count", 32'(got.size()), 32'(2));
    chk("f4_sum",   32'(got[0].sum),   32'(24));
    chk("f4_beats", 32'(got[0].beats), 32'(4));
    chk("f4_ovf",   32'(got[0].ovf),   32'(0));
    chk("f2_sum",   32'(got[1].sum),   32'(6));
    chk("f2_beats", 32'(got[1].beats), 32'(2));

    // Count zeros under a mask
    got.delete();
    send(15'h0000, 15'h00F0, 1'b1, 1'b1);
    cycles(3);
    chk("mz_sum",   32'(got[0].sum),   32'(4));
    chk("mz_beats", 32'(got[0].beats), 32'(1));

    // Backpressure: one result held, next frame queued behind it
    got.delete();
    bus_m.out_ready = 1'b0;
    send(15'h7FFF, 15'h7FFF, 1'b0, 1'b0);
    send(15'h0001, 15'h7FFF, 1'b0, 1'b1);
    fork
      send(15'h00FF, 15'h7FFF, 1'b0, 1'b1);
    join_none
    cycles(4);
    chk("bp_in_ready", 32'(bus_m.in_ready),  32'(0));
    chk("bp_valid",    32'(bus_m.out_valid), 32'(1));
    chk("bp_sum",      32'(bus_m.out_sum),   32'(16));
    chk("bp_none_out", 32'(got.size()),      32'(0));
    bus_m.out_ready = 1'b1;
    cycles(1);
    bus_m.out_ready = 1'b0;
    cycles(3);
    chk("bp_one_out", 32'(got.size()),      32'(1));
    chk("bp_a_beats", 32'(got[0].beats),    32'(2));
    chk("bp_b_valid", 32'(bus_m.out_valid), 32'(1));
    chk("bp_b_sum",   32'(bus_m.out_sum),   32'(8));
    bus_m.out_ready = 1'b1;
    cycles(2);
    chk("bp_two_out", 32'(got.size()), 32'(2));

    // clr mid-frame discards partial state and the beat presented with it
    got.delete();
    send(15'h7FFF, 15'h7FFF, 1'b0, 1'b0);
    send(15'h7FFF, 15'h7FFF, 1'b0, 1'b0);
    cycles(2);
    clr = 1'b1;
    bus_m.in_valid = 1'b1; bus_m.in_data = 15'h7FFF; bus_m.in_last = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", 32'(bus_m.in_ready), 32'(0));
    @(posedge clk); #1;
    clr = 1'b0; bus_m.in_valid = 1'b0;
    chk("clr_valid", 32'(bus_m.out_valid), 32'(0));
    send(15'h0003, 15'h7FFF, 1'b0, 1'b1);
    cycles(3);
    chk("clr_count", 32'(got.size()),   32'(1));
    chk("clr_sum",   32'(got[0].sum),   32'(2));
    chk("clr_beats", 32'(got[0].beats), 32'(1));

    // Exhaustive single-beat sweep at full throughput
    got.delete();
    for (int d = 0; d < 32768; d++) send(15'(d), 15'h7FFF, 1'b0, 1'b1);
    cycles(3);
    chk("sweep_count", 32'(got.size()), 32'(32768));

    // Random beats with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 600; i++)
      send(15'($urandom), 15'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));
    send(15'($urandom), 15'h7FFF, 1'b0, 1'b1);
    rand_rdy = 1'b0;
    cycles(1);
    bus_m.out_ready = 1'b1;
    cycles(5);
    chk("rand_drained", 32'(exp_q.size()), 32'(0));

    // Async reset with a pending result drops out_valid immediately
    bus_m.out_ready = 1'b0;
    send(15'h7FFF, 15'h7FFF, 1'b0, 1'b1);
    cycles(2);
    chk("prerst_valid", 32'(bus_m.out_valid), 32'(1));
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(bus_m.out_valid), 32'(0));
    chk("arst_sum",   32'(bus_m.out_sum),   32'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    bus_m.out_ready = 1'b1;

    // Async reset mid-frame discards the partial frame
    got.delete();
    send(15'h7FFF, 15'h7FFF, 1'b0, 1'b0);
    cycles(2);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    send(15'h0001, 15'h7FFF, 1'b0, 1'b1);
    cycles(3);
    chk("rstf_count", 32'(got.size()),   32'(1));
    chk("rstf_sum",   32'(got[0].sum),   32'(1));
    chk("rstf_beats", 32'(got[0].beats), 32'(1));

    // ACC_W=5, PIPE_STG=0: overflow and same-edge result
    send_s(15'h7FFF, 1'b0);
    chk("s_mid_valid", 32'(bus_s.out_valid), 32'(0));
    send_s(15'h7FFF, 1'b0);
    send_s(15'h7FFF, 1'b1);
    chk("s_lat0_valid", 32'(bus_s.out_valid), 32'(1));
    chk("s_ovf_sum",    32'(bus_s.out_sum),   32'(OVF_SUM));
    chk("s_ovf_beats",  32'(bus_s.out_beats), 32'(3));
    chk("s_ovf_flag",   32'(bus_s.out_ovf),   32'(1));
    send_s(15'h0001, 1'b1);
    chk("s_next_sum",  32'(bus_s.out_sum),   32'(1));
    chk("s_next_ovf",  32'(bus_s.out_ovf),   32'(0));
    cycles(1);
    chk("s_drop_valid", 32'(bus_s.out_valid), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/popcount_accum_pipe.md
Name: popcount_accum_pipe

Overview:
- Parametrised successor to the fixed 15-to-4 / 7-to-3 / 6-to-3 bit-count compressors in the NPU datapath.
- Each accepted beat is an IN_W-bit vector. The block computes the masked popcount of ones (or zeros) in a pipelined compressor tree.
- Counts are accumulated over a frame delimited by in_last, and the frame total and beat count are presented on a valid/ready output.
- Used for binary-activation sparsity statistics and XNOR-popcount dot products in the PE array.

Parameters:
- IN_W, 15: input vector width, 2..64. CW = clog2(IN_W+1) is the per-beat count width.
- ACC_W, 16: width of the sum and beat accumulators; must be >= CW.
- PIPE_STG, 1: register stages inside the compressor tree, 0..3.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- clr, input, 1: synchronous flush of the frame, pipeline and output.
- mode_zero, input, 1: 0 counts ones, 1 counts zeros; sampled per beat.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block can accept a beat.
- in_data, input, IN_W: bit vector.
- in_mask, input, IN_W: per-bit enable; masked-off bits never count.
- in_last, input, 1: final beat of the frame.
- out_valid, output, 1: frame result valid.
- out_ready, input, 1: consumer accepts the result.
- out_sum, output, ACC_W: frame popcount total.
- out_beats, output, ACC_W: number of beats in the frame.
- out_ovf, output, 1: sum or beat accumulator overflowed during the frame.

Behaviour:
- Reset (reset=0, asynchronous): all pipeline valid bits 0, accumulators 0, out_valid=0, out_sum=0, out_beats=0, out_ovf=0. in_ready=1 after release.
- Per-beat count: cnt = popcount((mode_zero ? ~in_data : in_data) & in_mask), range 0..IN_W. The value must be bit-exact against a behavioural sum of bits.
- Stall enable: en = !(out_valid && !out_ready). in_ready = en. The entire pipeline, accumulators and output register advance only when en=1. A beat is accepted on an edge where in_valid && in_ready.
- Pipeline: PIPE_STG register stages. Each stage carries {partial counts, valid, last}. Bubbles propagate with valid=0 and never touch the accumulators.
- Accumulate: when a valid beat exits the tree with en=1:
  - sum_acc += cnt and beat_acc += 1.
  - Overflow of either accumulator sets the sticky ovf_acc.
- Frame close: when the exiting beat has last=1:
  - out_sum = sum_acc + cnt, out_beats = beat_acc + 1, out_ovf = ovf_acc or the overflow on this add. out_valid is set to 1.
  - sum_acc, beat_acc and ovf_acc are cleared in the same edge, so the next frame starts at 0 with no lost beat.
- Latency: a last beat accepted at edge E gives out_valid=1 after edge E+PIPE_STG. With PIPE_STG=0 that is the same edge E.
- Throughput: one beat per clock while out_ready=1 or out_valid=0.
- Output handshake:
  - out_valid, out_sum, out_beats and out_ovf are held stable until out_valid && out_ready.
  - If out_ready=1 in the same cycle another last beat exits, the new result replaces the old one in that edge and out_valid stays 1.
  - Otherwise out_valid drops after the handshake.
- Single-beat frame (in_last on the first beat) is legal: out_beats=1.
- clr=1 on an edge: clears pipeline valid bits, accumulators, ovf_acc and out_valid. out_sum and out_beats keep their values. Any beat presented with clr=1 is discarded. clr has priority over all other events, and in_ready=0 while clr=1.
- Reset mid-frame discards all partial state immediately.

Optional Feature:
- Macro POPCNT_SAT_EN.
- Defined: sum_acc and beat_acc saturate at 2^ACC_W-1 instead of wrapping. out_ovf still flags that saturation occurred.
- Undefined: both accumulators wrap modulo 2^ACC_W, and out_ovf flags the wrap.
- Latency and handshake are identical in both builds.

Test Plan:
- Exhaustive count check, IN_W=15, PIPE_STG=1, mask=7FFF, mode_zero=0, every beat last, out_ready=1:
  - Sweep in_data 0000..7FFF.
  - Each out_sum equals the popcount of in_data, e.g. 7FFF gives 15 and 5555 gives 8; out_beats=1.
  - out_valid rises 1 edge after each acceptance.
- Frame of 4 beats: in_data {7FFF, 0001, 0000, 00FF}, mask=7FFF, last on beat 4 → out_sum=24, out_beats=4, out_ovf=0. A second frame started back-to-back yields an independent result.
- mode_zero=1, in_data=0000, in_mask=00F0, single-beat frame → out_sum=4. Masked zeros are not counted.
- Backpressure: out_ready=0 while a result is pending → in_ready=0, no beat is lost, outputs are stable. Raising out_ready for 1 cycle releases exactly one result, after which the next queued frame completes.
- Overflow, ACC_W=5: frame of 3 beats of 7FFF (45 ones) →
  - POPCNT_SAT_EN undefined: out_sum=13 (45 mod 32), out_ovf=1.
  - POPCNT_SAT_EN defined: out_sum=31, out_ovf=1.
- clr asserted mid-frame after 2 beats, then a new single-beat frame 0003 → out_sum=2, out_beats=1. Asynchronous reset mid-frame forces out_valid=0 immediately.
